// File: rtl/phase_backcnt_pkg.sv
// Shared types and helpers for the phase back-counter.
// Holds the FSM state encoding, default widths and the mode-advance rule.
package phase_backcnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT  = 6;
    localparam int MODE_W_DEFAULT = 2;

    // Mode chosen at a load point. Auto-advance steps mode_q and wraps after
    // the last valid mode. Otherwise the requested mode is used, and any index
    // outside the valid range falls back to mode 0.
    function automatic int next_mode_f(
        input int   mode_q,
        input int   mode,
        input logic auto_adv,
        input int   num_modes
    );
        if (auto_adv) begin
            return (mode_q >= num_modes - 1) ? 0 : mode_q + 1;
        end
        return (mode >= num_modes) ? 0 : mode;
    endfunction

endpackage

// File: rtl/phase_dur_mux.sv
// Duration selector: returns the CNT_W-bit field of dur_vec addressed by idx.
// An index at or beyond NUM_MODES selects the mode-0 field.
module phase_dur_mux #(
    parameter int CNT_W     = 6,
    parameter int MODE_W    = 2,
    parameter int NUM_MODES = 4
) (
    input  logic [NUM_MODES*CNT_W-1:0] dur_vec,
    input  logic [MODE_W-1:0]          idx,
    output logic [CNT_W-1:0]           dur
);

    // Pick the addressed duration field, defaulting to mode 0.
    always_comb begin
        // NOTE: assigning dur before the loop covers every path, so no latch is inferred.
        dur = dur_vec[0 +: CNT_W];
        for (int i = 1; i < NUM_MODES; i++) begin
            if (int'(idx) == i) begin
                dur = dur_vec[i*CNT_W +: CNT_W];
            end
        end
    end

endmodule

// File: rtl/phase_backcounter.sv
// Multi-mode seconds down-counter for the traffic-light controller.
// It counts 1 Hz pulses down from the active phase duration. At the end of a
// phase it emits a one-clock timeout and reloads the next phase.
// Optional feature: define PHASE_BACKCNT_WARN_EN to add the registered `warn`
// output. warn is high while the RUN count lies within 1..WARN_T.
module phase_backcounter
    import phase_backcnt_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int MODE_W    = MODE_W_DEFAULT,
    parameter int NUM_MODES = 4
`ifdef PHASE_BACKCNT_WARN_EN
    ,
    parameter int WARN_T    = 3
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       pulse,
    input  logic                       pause,
    input  logic                       restart,
    input  logic                       auto_adv,
    input  logic [MODE_W-1:0]          mode,
    input  logic [NUM_MODES*CNT_W-1:0] dur_vec,
    output logic [CNT_W-1:0]           sec_count,
    output logic                       timeout,
    output logic [MODE_W-1:0]          mode_q,
    output logic                       running
`ifdef PHASE_BACKCNT_WARN_EN
    ,
    output logic                       warn
`endif
);

    state_t            state, state_d;
    logic [CNT_W-1:0]  sec_d;
    logic [MODE_W-1:0] mode_d;
    logic              timeout_d;
    logic [MODE_W-1:0] ld_mode;
    logic [CNT_W-1:0]  ld_dur;

    // Mode used by any load that happens on this edge. The initial load from
    // IDLE ignores auto_adv. A restart keeps the current mode. A terminal
    // pulse applies the advance rule.
    always_comb begin
        if (state == IDLE) begin
            ld_mode = MODE_W'(next_mode_f(int'(mode_q), int'(mode), 1'b0, NUM_MODES));
        end else if (restart) begin
            ld_mode = mode_q;
        end else begin
            ld_mode = MODE_W'(next_mode_f(int'(mode_q), int'(mode), auto_adv, NUM_MODES));
        end
    end

    phase_dur_mux #(
        .CNT_W     (CNT_W),
        .MODE_W    (MODE_W),
        .NUM_MODES (NUM_MODES)
    ) u_dur_mux (
        .dur_vec (dur_vec),
        .idx     (ld_mode),
        .dur     (ld_dur)
    );

    // Next-state and counter rules. Priority is en=0 > restart > pause > pulse.
    always_comb begin
        state_d   = state;
        sec_d     = sec_count;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        if (!en) begin
            // A terminal pulse on this edge is dropped and no timeout is produced.
            state_d = IDLE;
            sec_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Restart and pause have no extra effect here: IDLE always loads and runs.
                    state_d = RUN;
                    sec_d   = ld_dur;
                    mode_d  = ld_mode;
                end
                RUN, PAUSE: begin
                    if (restart) begin
                        sec_d   = ld_dur;
                        state_d = pause ? PAUSE : RUN;
                    end else if (pause) begin
                        state_d = PAUSE;
                    end else if (state == PAUSE) begin
                        // A pulse that arrives on the resume edge is discarded.
                        state_d = RUN;
                    end else if (pulse) begin
                        if (sec_count != '0) begin
                            sec_d = sec_count - CNT_W'(1);
                        end else begin
                            timeout_d = 1'b1;
                            sec_d     = ld_dur;
                            mode_d    = ld_mode;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    sec_d   = '0;
                end
            endcase
        end
    end

    // State register. All outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the pre-edge values.
        if (rst) begin
            state     <= IDLE;
            sec_count <= '0;
            timeout   <= 1'b0;
            mode_q    <= '0;
            running   <= 1'b0;
`ifdef PHASE_BACKCNT_WARN_EN
            warn      <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            sec_count <= sec_d;
            timeout   <= timeout_d;
            mode_q    <= mode_d;
            running   <= (state_d == RUN);
`ifdef PHASE_BACKCNT_WARN_EN
            warn      <= (state_d == RUN) && (sec_d != '0) && (sec_d <= CNT_W'(WARN_T));
`endif
        end
    end

endmodule

// File: tb/tb_phase_backcounter.sv
// Self-checking bench for phase_backcounter.
// A behavioural model checks the outputs every cycle, and directed literal
// checks pin the model. The stimulus is a directed sequence followed by
// randomized traffic.
module tb_phase_backcounter;

    localparam int CNT_W  = 6;
    localparam int MODE_W = 2;
    localparam int NM     = 4;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b1;
    logic                  en       = 1'b0;
    logic                  pulse    = 1'b0;
    logic                  pause    = 1'b0;
    logic                  restart  = 1'b0;
    logic                  auto_adv = 1'b0;
    logic [MODE_W-1:0]     mode     = '0;
    logic [NM*CNT_W-1:0]   dur_vec  = '0;
    logic [CNT_W-1:0]      sec_count;
    logic                  timeout;
    logic [MODE_W-1:0]     mode_q;
    logic                  running;

    // Second instance with three modes, used for the out-of-range mode case.
    logic                  en3      = 1'b0;
    logic [MODE_W-1:0]     mode3    = '0;
    logic [3*CNT_W-1:0]    dur_vec3 = {6'd7, 6'd8, 6'd9};
    logic [CNT_W-1:0]      sec_count3;
    logic                  timeout3;
    logic [MODE_W-1:0]     mode_q3;
    logic                  running3;
`ifdef PHASE_BACKCNT_WARN_EN
    logic                  warn;
    logic                  warn3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    phase_backcounter #(.CNT_W(CNT_W), .MODE_W(MODE_W), .NUM_MODES(NM)) dut (
        .clk(clk), .rst(rst), .en(en), .pulse(pulse), .pause(pause),
        .restart(restart), .auto_adv(auto_adv), .mode(mode), .dur_vec(dur_vec),
        .sec_count(sec_count), .timeout(timeout), .mode_q(mode_q), .running(running)
`ifdef PHASE_BACKCNT_WARN_EN
        , .warn(warn)
`endif
    );

    phase_backcounter #(.CNT_W(CNT_W), .MODE_W(MODE_W), .NUM_MODES(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .pulse(pulse), .pause(pause),
        .restart(restart), .auto_adv(auto_adv), .mode(mode3), .dur_vec(dur_vec3),
        .sec_count(sec_count3), .timeout(timeout3), .mode_q(mode_q3), .running(running3)
`ifdef PHASE_BACKCNT_WARN_EN
        , .warn(warn3)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_started = 1'b0;
    bit m_active  = 1'b0;
    bit m_paused  = 1'b0;
    bit m_to      = 1'b0;
    int m_sec     = 0;
    int m_mode    = 0;

    function automatic int dur_of(input int i);
        return int'((dur_vec >> (i * CNT_W)) & 24'h3f);
    endfunction

    function automatic int req_mode();
        return (int'(mode) < NM) ? int'(mode) : 0;
    endfunction

    always @(posedge clk) begin
        m_to = 1'b0;
        if (rst) begin
            m_started = 1'b1;
            m_active  = 1'b0;
            m_paused  = 1'b0;
            m_sec     = 0;
            m_mode    = 0;
        end else if (!en) begin
            m_active = 1'b0;
            m_paused = 1'b0;
            m_sec    = 0;
        end else if (!m_active) begin
            m_mode   = req_mode();
            m_sec    = dur_of(m_mode);
            m_active = 1'b1;
            m_paused = 1'b0;
        end else if (restart) begin
            m_sec    = dur_of(m_mode);
            m_paused = pause;
        end else if (pause) begin
            m_paused = 1'b1;
        end else if (m_paused) begin
            m_paused = 1'b0;
        end else if (pulse) begin
            if (m_sec > 0) begin
                m_sec = m_sec - 1;
            end else begin
                m_to   = 1'b1;
                m_mode = auto_adv ? (m_mode + 1) % NM : req_mode();
                m_sec  = dur_of(m_mode);
            end
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("model_sec_count", 32'(sec_count), 32'(m_sec));
            check("model_timeout",   32'(timeout),   32'(m_to));
            check("model_mode_q",    32'(mode_q),    32'(m_mode));
            check("model_running",   32'(running),   32'(m_active && !m_paused));
`ifdef PHASE_BACKCNT_WARN_EN
            check("model_warn", 32'(warn),
                  32'(m_active && !m_paused && m_sec > 0 && m_sec <= 3));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        tick(1);
        pulse = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            do_pulse();
            tick(1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and initial load.
        tick(2);
        check("reset_sec_count", 32'(sec_count), 0);
        check("reset_timeout",   32'(timeout),   0);
        check("reset_mode_q",    32'(mode_q),    0);
        check("reset_running",   32'(running),   0);
        rst = 1'b0; en = 1'b1; mode = 2'd1;
        dur_vec = {6'd4, 6'd3, 6'd5, 6'd10};
        tick(1);
        check("load_sec_count", 32'(sec_count), 5);
        check("load_mode_q",    32'(mode_q),    1);
        check("load_running",   32'(running),   1);
        pulses(5);
        check("count_to_zero", 32'(sec_count), 0);
        do_pulse();
        check("terminal_timeout", 32'(timeout),   1);
        check("terminal_reload",  32'(sec_count), 5);
        tick(1);
        check("timeout_one_clk", 32'(timeout), 0);

        // Auto advance wraps from mode 3 to mode 0.
        en = 1'b0;
        tick(1);
        check("idle_sec_count", 32'(sec_count), 0);
        check("idle_running",   32'(running),   0);
        mode = 2'd3; auto_adv = 1'b1; en = 1'b1;
        tick(1);
        check("auto_start_sec", 32'(sec_count), 4);
        pulses(4);
        do_pulse();
        check("auto_timeout", 32'(timeout),   1);
        check("auto_wrap",    32'(mode_q),    0);
        check("auto_reload",  32'(sec_count), 10);
        tick(1);

        // Pause holds the count and drops pulses.
        pulses(3);
        check("pre_pause_sec", 32'(sec_count), 7);
        pause = 1'b1;
        tick(1);
        pulses(3);
        check("paused_sec",     32'(sec_count), 7);
        check("paused_running", 32'(running),   0);
        pause = 1'b0;
        tick(1);
        check("resume_running", 32'(running), 1);
        do_pulse();
        check("resume_count", 32'(sec_count), 6);
        pause = 1'b1; pulse = 1'b1;
        tick(1);
        pulse = 1'b0;
        check("pause_beats_pulse", 32'(sec_count), 6);
        pause = 1'b0;
        tick(1);

        // Restart and disable on a terminal pulse.
        auto_adv = 1'b0; en = 1'b0;
        tick(1);
        mode = 2'd2; en = 1'b1;
        tick(1);
        pulses(1);
        check("pre_restart_sec", 32'(sec_count), 2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("restart_sec",     32'(sec_count), 3);
        check("restart_no_to",   32'(timeout),   0);
        check("restart_mode_q",  32'(mode_q),    2);
        pulses(3);
        en = 1'b0; pulse = 1'b1;
        tick(1);
        pulse = 1'b0;
        check("en_drop_sec",     32'(sec_count), 0);
        check("en_drop_timeout", 32'(timeout),   0);
        check("en_drop_running", 32'(running),   0);

        // Zero duration: timeout on every pulse.
        dur_vec = {6'd4, 6'd3, 6'd5, 6'd0};
        mode = 2'd0; en = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            do_pulse();
            check("dur0_timeout", 32'(timeout),   1);
            check("dur0_sec",     32'(sec_count), 0);
            tick(1);
            check("dur0_low",     32'(timeout),   0);
        end

        // Mode index 3 with only three modes falls back to mode 0.
        mode3 = 2'd3; en3 = 1'b1;
        tick(1);
        check("nm3_mode_q",  32'(mode_q3),    0);
        check("nm3_sec",     32'(sec_count3), 9);
        check("nm3_running", 32'(running3),   1);
        en3 = 1'b0;

`ifdef PHASE_BACKCNT_WARN_EN
        // Warning window for a five-second phase.
        dur_vec = {6'd4, 6'd3, 6'd5, 6'd10};
        en = 1'b0;
        tick(1);
        mode = 2'd1; en = 1'b1;
        tick(1);
        check("warn_at_5", 32'(warn), 0);
        for (int s = 4; s >= 0; s--) begin
            do_pulse();
            check("warn_window", 32'(warn), 32'((s >= 1 && s <= 3) ? 1 : 0));
            tick(1);
        end
`endif

        // Randomized traffic checked by the model.
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 499) == 0);
            en      = ($urandom_range(0, 63) != 0);
            pulse   = !pulse && ($urandom_range(0, 3) == 0);
            pause   = pause ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            restart = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 99) == 0) auto_adv = ~auto_adv;
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                dur_vec = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            end
            tick(1);
        end
        rst = 1'b0; pulse = 1'b0; pause = 1'b0; restart = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_backcounter.md
Name: phase_backcounter

Overview:
- Parametrised, multi-mode seconds down-counter for the traffic-light controller.
- It supersedes the fixed two-duration counter. It provides:
  - NUM_MODES phase durations supplied at run time
  - a latched current mode
  - run, pause and restart control
  - optional automatic cycling through the phases
- It sits between the 1 Hz pulse generator and the light-sequencing FSM. Its one-cycle timeout advances the light phase.

Parameters:
- CNT_W, 6, width of the seconds count and of each duration field.
- MODE_W, 2, width of the mode index.
- NUM_MODES, 4, number of valid modes. Legal range is 2..2**MODE_W.
- WARN_T, 3, warning threshold in seconds. Used only when PHASE_BACKCNT_WARN_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable. When 0 the block is forced to IDLE.
- pulse  in  1  one-clk-wide tick, 1 per second.
- pause  in  1  freezes the count while high.
- restart  in  1  reloads the current phase duration.
- auto_adv  in  1  1 = next mode is mode_q+1 (wraps); 0 = next mode is sampled from `mode`.
- mode  in  MODE_W  requested mode. Sampled only at load points.
- dur_vec  in  NUM_MODES*CNT_W  duration of mode i in bits [i*CNT_W +: CNT_W].
- sec_count  out  CNT_W  remaining seconds.
- timeout  out  1  one-clk pulse at the end of a phase.
- mode_q  out  MODE_W  mode currently being timed.
- running  out  1  high in RUN.

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE, sec_count=0, timeout=0, mode_q=0, running=0.
- Load operation: next_mode = auto_adv ? ((mode_q==NUM_MODES-1) ? 0 : mode_q+1) : mode. Then mode_q<=next_mode and sec_count<=dur_vec[next_mode].
  - If mode >= NUM_MODES, treat it as 0.
- States:
  - IDLE: sec_count=0, timeout=0.
    - en=1 -> perform the initial load with mode (auto_adv is ignored for the initial load) and go to RUN.
    - The load happens on the same edge, independent of pulse.
  - RUN: running=1. On a pulse edge:
    - sec_count>0 -> decrement.
    - sec_count==0 -> timeout<=1 for exactly one clk, perform the load, stay in RUN.
  - PAUSE: sec_count and mode_q are held, pulses are discarded, running=0.
    - pause=0 -> RUN on the next edge. The first pulse counted is one that arrives after the return to RUN.
- Control priority per edge: rst > en=0 > restart > pause > pulse.
  - en=0 in any state -> IDLE with sec_count=0 on that edge. A pending terminal pulse is dropped and no timeout is produced.
  - restart (en=1): reload dur_vec[mode_q] and do not change mode_q. No timeout. The next state is PAUSE if pause=1, otherwise RUN. In IDLE, restart behaves like the initial load.
  - pause and pulse on the same edge: pause wins and the pulse is lost.
  - Entering PAUSE from RUN takes effect on the edge where pause=1 is sampled.
- Phase length: duration D gives D+1 pulses per phase; timeout coincides with the pulse that finds sec_count==0.
  - D=0 gives a timeout on every pulse.
- timeout is registered and low in every cycle except the terminal one. It never stays high for two consecutive cycles, because pulse is one clk wide.
- Arithmetic: unsigned CNT_W arithmetic. There is no underflow, because decrement occurs only when sec_count>0. Durations are used as given, without saturation.
- dur_vec changes take effect only at the next load or restart.

Optional Feature:
- Macro: PHASE_BACKCNT_WARN_EN.
- Defined:
  - Adds output port `warn` (1 bit), registered.
  - warn=1 when state==RUN and 0 < sec_count <= WARN_T; otherwise 0.
  - warn is also 0 in PAUSE and IDLE. Reset value is 0.
- Undefined: the `warn` port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package phase_backcnt_pkg contains:
  - state typedef enum {IDLE, RUN, PAUSE}
  - default CNT_W/MODE_W constants
  - the function next_mode_f(mode_q, mode, auto_adv, NUM_MODES) that implements the wrap rule
- One sub-module is natural: phase_dur_mux. It selects dur_vec[idx] combinationally and maps an out-of-range index to 0.
- Counter and FSM stay in phase_backcounter.

Test Plan:
- Reset and load: rst=1 for 2 clks, then en=1, mode=1, dur_vec={4,3,5,10} (mode3..0).
  - Expect sec_count 0 during reset; after load, sec_count=5 and mode_q=1.
  - 5 pulses bring it to 0; the 6th pulse gives timeout=1 for one clk and sec_count=5.
- Auto advance: auto_adv=1, start mode=3, dur 4.
  - At the 5th pulse, timeout fires, mode_q wraps to 0 and sec_count=10.
- Pause: sec_count=7, pause=1, 3 pulses.
  - Count stays 7 and running=0.
  - pause=0 then 1 pulse -> 6.
  - pause and pulse on the same edge -> pulse is ignored.
- Restart/en: restart at sec_count=2 with mode_q=2 -> sec_count=3 and no timeout.
  - en=0 on the terminal pulse edge -> IDLE, sec_count=0, timeout stays 0.
- Edge durations: dur=0 -> timeout on every pulse.
  - mode=3 with NUM_MODES=3 -> mode_q=0.
- WARN_EN build, WARN_T=3, dur=5: warn is high exactly while sec_count is 3, 2, 1 and low at 0.
  - A non-WARN build compiles without the port.
